// File: rtl/reg_mem_dp_if.sv
// Bus bundle for reg_mem_dp: clear control, read/write port A, read-only port B.
interface reg_mem_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  clr;
    logic                  busy;
    logic                  a_en;
    logic                  a_we;
    logic [DATA_W/8-1:0]   a_be;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_din;
    logic [DATA_W-1:0]     a_dout;
    logic                  a_rvalid;
    logic                  b_en;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_dout;
    logic                  b_rvalid;

    modport master (
        output clr, a_en, a_we, a_be, a_addr, a_din, b_en, b_addr,
        input  busy, a_dout, a_rvalid, b_dout, b_rvalid
    );

    modport slave (
        input  clr, a_en, a_we, a_be, a_addr, a_din, b_en, b_addr,
        output busy, a_dout, a_rvalid, b_dout, b_rvalid
    );
endinterface

// File: rtl/reg_mem_dp.sv
// Register memory with a byte-enable read/write port A, a read-only port B,
// registered read data with optional second output stage, and a clear engine
// that sweeps the array to INIT_VAL after reset or on a clr pulse.
module reg_mem_dp #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 10,
    parameter int                RDW_MODE       = 0,
    parameter int                OUT_REG        = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_mem_dp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BYTES = DATA_W / 8;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] CLEAR     = 1'b1;
    localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    // Counter carries one spare bit so the last address compares cleanly.
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              a_acc;
    logic              a_wr;
    logic              a_take;
    logic              b_acc;
    logic [DATA_W-1:0] a_old;
    logic [DATA_W-1:0] a_new;

    logic [DATA_W-1:0] a_dat_p0;
    logic [DATA_W-1:0] b_dat_p0;
    logic              vld_a_p0;
    logic              vld_b_p0;

    assign busy     = (state == CLEAR);
    assign bus.busy = busy;

    // Ports are ignored entirely while the sweep owns the array.
    assign a_acc  = !busy && bus.a_en;
    assign a_wr   = a_acc && bus.a_we;
    assign b_acc  = !busy && bus.b_en;
    // NO_CHANGE writes produce no read result; other modes return a word.
    assign a_take = a_acc && (!bus.a_we || (RDW_MODE != 0));
    assign a_old  = mem[bus.a_addr];

    // Byte-merge the incoming write data over the currently stored word.
    always_comb begin
        a_new = a_old;
        for (int i = 0; i < BYTES; i++) begin
            if (bus.a_be[i]) a_new[8*i +: 8] = bus.a_din[8*i +: 8];
        end
    end

    // Clear-engine FSM: sweep cnt over every address, then return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (bus.clr) begin
            state <= CLEAR;
            cnt   <= '0;
        end
    end

    // Array writes: the sweep has priority, port A only when idle.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt[ADDR_W-1:0]] <= INIT_VAL;
        end else if (a_wr) begin
            mem[bus.a_addr] <= a_new;
        end
    end

    // ---- stage p0: registered read data; data holds when no access ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dat_p0 <= '0;
            b_dat_p0 <= '0;
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
        end else begin
            vld_a_p0 <= a_take;
            vld_b_p0 <= b_acc;
            if (a_take) a_dat_p0 <= (bus.a_we && (RDW_MODE == 2)) ? a_new : a_old;
            if (b_acc)  b_dat_p0 <= mem[bus.b_addr];
        end
    end

    // ---- stage p1: optional output register ----
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] a_dat_p1;
            logic [DATA_W-1:0] b_dat_p1;
            logic              vld_a_p1;
            logic              vld_b_p1;

            // Second stage only captures data that was freshly read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_dat_p1 <= '0;
                    b_dat_p1 <= '0;
                    vld_a_p1 <= 1'b0;
                    vld_b_p1 <= 1'b0;
                end else begin
                    vld_a_p1 <= vld_a_p0;
                    vld_b_p1 <= vld_b_p0;
                    if (vld_a_p0) a_dat_p1 <= a_dat_p0;
                    if (vld_b_p0) b_dat_p1 <= b_dat_p0;
                end
            end

            assign bus.a_dout   = a_dat_p1;
            assign bus.a_rvalid = vld_a_p1;
            assign bus.b_dout   = b_dat_p1;
            assign bus.b_rvalid = vld_b_p1;
        end else begin : g_out_direct
            assign bus.a_dout   = a_dat_p0;
            assign bus.a_rvalid = vld_a_p0;
            assign bus.b_dout   = b_dat_p0;
            assign bus.b_rvalid = vld_b_p0;
        end
    endgenerate
endmodule

// File: tb/tb_reg_mem_dp.sv
// Scoreboard bench for reg_mem_dp: three instances (NO_CHANGE, READ_FIRST with
// output register, WRITE_FIRST) share one stimulus stream; a behavioural model
// queues expected read results with their due cycle.
module tb_reg_mem_dp;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clr    = 1'b0;
    logic        a_en   = 1'b0;
    logic        a_we   = 1'b0;
    logic [3:0]  a_be   = '0;
    logic [AW-1:0] a_addr = '0;
    logic [31:0] a_din  = '0;
    logic        b_en   = 1'b0;
    logic [AW-1:0] b_addr = '0;

    logic [31:0] a_dout_w [NI];
    logic [31:0] b_dout_w [NI];
    logic        a_vld_w  [NI];
    logic        b_vld_w  [NI];
    logic        busy_w   [NI];

    always #5 clk = ~clk;

    reg_mem_dp_if #(.DATA_W(32), .ADDR_W(AW)) bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].clr    = clr;
        assign bus[g].a_en   = a_en;
        assign bus[g].a_we   = a_we;
        assign bus[g].a_be   = a_be;
        assign bus[g].a_addr = a_addr;
        assign bus[g].a_din  = a_din;
        assign bus[g].b_en   = b_en;
        assign bus[g].b_addr = b_addr;
        assign a_dout_w[g]   = bus[g].a_dout;
        assign a_vld_w[g]    = bus[g].a_rvalid;
        assign b_dout_w[g]   = bus[g].b_dout;
        assign b_vld_w[g]    = bus[g].b_rvalid;
        assign busy_w[g]     = bus[g].busy;

        reg_mem_dp #(
            .DATA_W(32), .ADDR_W(AW), .RDW_MODE(g), .OUT_REG((g == 1) ? 1 : 0),
            .CLEAR_ON_RESET(1), .INIT_VAL(32'h0)
        ) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus[g])
        );
    end

    // Model state
    logic [31:0] mem_m [DEPTH];
    logic        busy_m;
    int          cnt_m;
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;
    exp_t        qa [NI][$];
    exp_t        qb [NI][$];
    logic [31:0] last_a [NI];
    logic [31:0] last_b [NI];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        return (old & ~mask) | (din & mask);
    endfunction

    function automatic int lat(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    task automatic compare();
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            logic        ev;
            logic [31:0] ed;
            check($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(busy_m));

            ev = (qa[g].size() > 0) && (qa[g][0].cyc == cyc);
            ed = last_a[g];
            if (ev) begin
                e  = qa[g].pop_front();
                ed = e.data;
            end
            check($sformatf("a_rvalid[%0d]", g), 32'(a_vld_w[g]), 32'(ev));
            check($sformatf("a_dout[%0d]", g), a_dout_w[g], ed);
            last_a[g] = ed;

            ev = (qb[g].size() > 0) && (qb[g][0].cyc == cyc);
            ed = last_b[g];
            if (ev) begin
                e  = qb[g].pop_front();
                ed = e.data;
            end
            check($sformatf("b_rvalid[%0d]", g), 32'(b_vld_w[g]), 32'(ev));
            check($sformatf("b_dout[%0d]", g), b_dout_w[g], ed);
            last_b[g] = ed;
        end
    endtask

    task automatic model_reset();
        busy_m = 1'b1;
        cnt_m  = 0;
        for (int g = 0; g < NI; g++) begin
            qa[g].delete();
            qb[g].delete();
            last_a[g] = '0;
            last_b[g] = '0;
        end
    endtask

    // One clock: predict from pre-edge state, advance model, then compare.
    task automatic cycle();
        logic [31:0]   merged;
        logic          do_wr;
        logic [AW-1:0] wa;
        do_wr  = 1'b0;
        merged = '0;
        wa     = a_addr;
        if (!busy_m) begin
            if (a_en) begin
                merged = merge(mem_m[a_addr], a_din, a_be);
                for (int g = 0; g < NI; g++) begin
                    if (!a_we)       qa[g].push_back('{data: mem_m[a_addr], cyc: cyc + lat(g)});
                    else if (g == 1) qa[g].push_back('{data: mem_m[a_addr], cyc: cyc + lat(g)});
                    else if (g == 2) qa[g].push_back('{data: merged, cyc: cyc + lat(g)});
                end
                do_wr = a_we;
            end
            if (b_en) begin
                for (int g = 0; g < NI; g++)
                    qb[g].push_back('{data: mem_m[b_addr], cyc: cyc + lat(g)});
            end
        end
        @(posedge clk);
        cyc++;
        if (do_wr) mem_m[wa] = merged;
        if (busy_m) begin
            mem_m[cnt_m] = 32'h0;
            if (cnt_m == DEPTH - 1) busy_m = 1'b0;
            else cnt_m++;
        end else if (clr) begin
            busy_m = 1'b1;
            cnt_m  = 0;
        end
        #1;
        compare();
    endtask

    task automatic idle_in();
        clr  = 1'b0;
        a_en = 1'b0;
        a_we = 1'b0;
        a_be = '0;
        b_en = 1'b0;
    endtask

    task automatic run(input int n);
        idle_in();
        repeat (n) cycle();
    endtask

    task automatic set_wr(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_din = d; a_be = be;
    endtask

    task automatic set_rd(input logic [AW-1:0] addr);
        a_en = 1'b1; a_we = 1'b0; a_addr = addr; a_be = '0;
    endtask

    task automatic set_b(input logic [AW-1:0] addr);
        b_en = 1'b1; b_addr = addr;
    endtask

    task automatic read_all_b();
        for (int i = 0; i < DEPTH; i++) begin
            idle_in();
            set_b(AW'(i));
            cycle();
        end
        run(3);
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) begin
            idle_in();
            set_wr(AW'(i), 32'h5A000000 | 32'(i) | ($urandom() & 32'h00FFFF00), 4'hF);
            cycle();
        end
        run(3);
    endtask

    initial begin
        // Power-on reset: outputs zero, busy high, sweep pending.
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        // Automatic sweep: busy for exactly DEPTH cycles, then all INIT_VAL.
        run(DEPTH);
        run(1);
        read_all_b();

        // Byte-enable write over zero, then read back.
        idle_in(); set_wr(4'd5, 32'hDEADBEEF, 4'b0101); cycle();
        idle_in(); set_rd(4'd5); cycle();
        run(3);
        // Empty byte-enable writes nothing.
        idle_in(); set_wr(4'd5, 32'hFFFFFFFF, 4'b0000); cycle();
        idle_in(); set_rd(4'd5); cycle();
        run(3);

        // Read-during-write mode sweep.
        idle_in(); set_wr(4'd3, 32'h11111111, 4'hF); cycle();
        idle_in(); set_wr(4'd3, 32'h22222222, 4'hF); cycle();
        idle_in(); set_rd(4'd3); cycle();
        run(3);

        // Same-cycle A write / B read, then B read again.
        idle_in(); set_wr(4'd7, 32'hA5A5A5A5, 4'hF); set_b(4'd7); cycle();
        idle_in(); set_b(4'd7); cycle();
        run(3);

        // Back-to-back A and B reads.
        for (int i = 0; i < 6; i++) begin
            idle_in(); set_rd(AW'(i + 2)); set_b(AW'(7 - i)); cycle();
        end
        run(3);

        // clr in IDLE, again mid-sweep, with port traffic during busy.
        fill_all();
        idle_in(); clr = 1'b1; cycle();
        for (int k = 0; k < DEPTH; k++) begin
            idle_in();
            set_wr(4'd0, 32'hC0DE0000 | 32'(k), 4'hF);
            set_b(AW'(k));
            if (k == 6) clr = 1'b1;
            cycle();
        end
        idle_in(); set_rd(4'd0); set_b(4'd0); cycle();
        run(2);
        read_all_b();

        // Reset mid-sweep at cnt=9; the sweep must restart from address 0.
        fill_all();
        idle_in(); clr = 1'b1; cycle();
        run(9);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        run(DEPTH);
        run(1);
        read_all_b();

        // Random mixed traffic.
        for (int i = 0; i < 300; i++) begin
            idle_in();
            a_en   = ($urandom_range(0, 3) != 0);
            a_we   = $urandom_range(0, 1) == 1;
            a_be   = 4'($urandom_range(0, 15));
            a_addr = AW'($urandom_range(0, DEPTH - 1));
            a_din  = $urandom();
            b_en   = ($urandom_range(0, 2) != 0);
            b_addr = AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        run(4);

        for (int g = 0; g < NI; g++) begin
            check($sformatf("drain_a[%0d]", g), 32'(qa[g].size()), 32'd0);
            check($sformatf("drain_b[%0d]", g), 32'(qb[g].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
